// File: rtl/secded_ctrl.sv
// secded_ctrl: sequencing controller for the SEC-DED datapath.
// All state updates happen on the falling edge of CLKb; RSTb is an async
// active-low reset.
//
// Ports:
//   CLKb, RSTb            clock (falling edge active), async reset
//   req, op               request handshake; op 0 = write, 1 = read
//   single_err/double_err decoder status for the codeword register
//   clr_cnt               synchronous clear of both error counters
//   ack, busy             completion pulse / not-idle indicator
//   E_din/E_cw/E_dout     load enables for the negedge data registers
//   err_corr/err_ue       classification of the last read
//   corr_cnt/ue_cnt       saturating error counters (CW bits)

// Saturating up-counter; clear wins over increment.
module secded_satcnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (inc && (cnt != '1))  cnt <= cnt + 1'b1;
  end
endmodule

module secded_ctrl #(
  parameter int ENC_LAT = 1,
  parameter int CW      = 8
) (
  input  logic          CLKb,
  input  logic          RSTb,
  input  logic          req,
  input  logic          op,
  input  logic          single_err,
  input  logic          double_err,
  input  logic          clr_cnt,
  output logic          ack,
  output logic          busy,
  output logic          E_din,
  output logic          E_cw,
  output logic          E_dout,
  output logic          err_corr,
  output logic          err_ue,
  output logic [CW-1:0] corr_cnt,
  output logic [CW-1:0] ue_cnt
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ENC   = 3'd2,
    STORE = 3'd3,
    FETCH = 3'd4,
    CHECK = 3'd5,
    OUT   = 3'd6,
    DONE  = 3'd7
  } state_t;

  // ENC is left when the counter reaches zero, so it is preloaded with
  // ENC_LAT-1 to spend exactly ENC_LAT cycles there.
  localparam logic [3:0] ENC_INIT = 4'(ENC_LAT - 1);

  state_t     state;
  logic [3:0] enc_cnt;

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state    <= IDLE;
      enc_cnt  <= '0;
      err_corr <= 1'b0;
      err_ue   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          err_corr <= 1'b0;
          err_ue   <= 1'b0;
          state    <= op ? FETCH : LOAD;
        end
        LOAD: begin
          enc_cnt <= ENC_INIT;
          state   <= ENC;
        end
        ENC: begin
          if (enc_cnt == 4'd0) state   <= STORE;
          else                 enc_cnt <= enc_cnt - 4'd1;
        end
        STORE: state <= DONE;
        FETCH: state <= CHECK;
        CHECK: begin
          // double_err dominates: a word flagged both ways is uncorrectable
          if (double_err) begin
            err_ue <= 1'b1;
            state  <= DONE;
          end else begin
            if (single_err) err_corr <= 1'b1;
            state <= OUT;
          end
        end
        OUT:     state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode straight off the state register: reset forces all low.
  assign busy   = (state != IDLE);
  assign ack    = (state == DONE);
  assign E_din  = (state == LOAD);
  assign E_cw   = (state == STORE) || (state == FETCH);
  assign E_dout = (state == OUT);

  // [0] = corrected, [1] = uncorrectable
  logic [1:0]         inc;
  logic [1:0][CW-1:0] cnt;

  assign inc[0] = (state == CHECK) && single_err && !double_err;
  assign inc[1] = (state == CHECK) && double_err;

  for (genvar i = 0; i < 2; i++) begin : g_cnt
    secded_satcnt #(.CW(CW)) u_cnt (
      .clk   (CLKb),
      .rst_n (RSTb),
      .clr   (clr_cnt),
      .inc   (inc[i]),
      .cnt   (cnt[i])
    );
  end

  assign corr_cnt = cnt[0];
  assign ue_cnt   = cnt[1];
endmodule

// File: tb/tb_secded_ctrl.sv
// Scoreboard bench for secded_ctrl (ENC_LAT=2, CW=2). The stimulus process
// pushes the expected completion of each request; the monitor pops and
// compares on every ack. Cycle n is the period after the n-th falling edge.
module tb_secded_ctrl;
  localparam int ENC_LAT = 2;
  localparam int CW      = 2;

  logic          CLKb, RSTb, req, op, single_err, double_err, clr_cnt;
  logic          ack, busy, E_din, E_cw, E_dout, err_corr, err_ue;
  logic [CW-1:0] corr_cnt, ue_cnt;

  secded_ctrl #(.ENC_LAT(ENC_LAT), .CW(CW)) dut (
    .CLKb(CLKb), .RSTb(RSTb), .req(req), .op(op),
    .single_err(single_err), .double_err(double_err), .clr_cnt(clr_cnt),
    .ack(ack), .busy(busy), .E_din(E_din), .E_cw(E_cw), .E_dout(E_dout),
    .err_corr(err_corr), .err_ue(err_ue), .corr_cnt(corr_cnt), .ue_cnt(ue_cnt)
  );

  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  int cyc = 0;
  always @(negedge CLKb) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int ack_c;
    int din_c, din_n;
    int cw_c, cw_n;
    int dout_c, dout_n;
    int busy_n;
    int ecorr, eue;
    int ccnt, ucnt;
  } exp_t;

  exp_t q[$];

  // ---------------- monitor ----------------
  int din_c, din_n, cw_c, cw_n, dout_c, dout_n, busy_n;

  task automatic clr_track();
    din_c = -1; din_n = 0; cw_c = -1; cw_n = 0;
    dout_c = -1; dout_n = 0; busy_n = 0;
  endtask

  initial clr_track();

  always @(posedge CLKb) begin
    if (!RSTb) clr_track();
    else begin
      if (busy)   busy_n++;
      if (E_din)  begin din_n++;  din_c  = cyc; end
      if (E_cw)   begin cw_n++;   cw_c   = cyc; end
      if (E_dout) begin dout_n++; dout_c = cyc; end
      if (ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_cycle",  cyc,            e.ack_c);
          chk("din_cycle",  din_c,          e.din_c);
          chk("din_count",  din_n,          e.din_n);
          chk("cw_cycle",   cw_c,           e.cw_c);
          chk("cw_count",   cw_n,           e.cw_n);
          chk("dout_cycle", dout_c,         e.dout_c);
          chk("dout_count", dout_n,         e.dout_n);
          chk("busy_count", busy_n,         e.busy_n);
          chk("err_corr",   int'(err_corr), e.ecorr);
          chk("err_ue",     int'(err_ue),   e.eue);
          chk("corr_cnt",   int'(corr_cnt), e.ccnt);
          chk("ue_cnt",     int'(ue_cnt),   e.ucnt);
        end
        clr_track();
      end
    end
  end

  always @(posedge CLKb)
    if (cyc > 3000) begin
      $display("FAIL watchdog actual=%0d expected<=3000", cyc);
      $fatal(1, "watchdog");
    end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLKb); #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"},      int'(ack),      0);
    chk({tag, "_busy"},     int'(busy),     0);
    chk({tag, "_E_din"},    int'(E_din),    0);
    chk({tag, "_E_cw"},     int'(E_cw),     0);
    chk({tag, "_E_dout"},   int'(E_dout),   0);
    chk({tag, "_err_corr"}, int'(err_corr), 0);
    chk({tag, "_err_ue"},   int'(err_ue),   0);
    chk({tag, "_corr_cnt"}, int'(corr_cnt), 0);
    chk({tag, "_ue_cnt"},   int'(ue_cnt),   0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  int last_ack = 0;

  // Issue one request with hand-derived latencies; exp_c/exp_u are the
  // counter values expected at completion. keep leaves req high so the next
  // call runs back to back; clr pulses clr_cnt during the CHECK cycle.
  task automatic issue(input bit o, input bit se, input bit de, input bit clr,
                       input bit keep, input bit b2b, input int exp_c, input int exp_u);
    exp_t e;
    int k, lat;
    wait_idle();
    if (b2b) chk("b2b_start", cyc, last_ack + 1);
    op = o; single_err = se; double_err = de; req = 1'b1;
    k = cyc;
    lat = (o == 1'b0) ? 3 + ENC_LAT : (de ? 3 : 4);
    e.ack_c  = k + lat;
    e.din_c  = (o == 1'b0) ? k + 1 : -1;
    e.din_n  = (o == 1'b0) ? 1 : 0;
    e.cw_c   = (o == 1'b0) ? k + 2 + ENC_LAT : k + 1;
    e.cw_n   = 1;
    e.dout_c = (o == 1'b1 && !de) ? k + 3 : -1;
    e.dout_n = (o == 1'b1 && !de) ? 1 : 0;
    e.busy_n = lat;
    e.ecorr  = (o == 1'b1 && se && !de) ? 1 : 0;
    e.eue    = (o == 1'b1 && de) ? 1 : 0;
    e.ccnt   = exp_c;
    e.ucnt   = exp_u;
    q.push_back(e);
    tick();                       // k+1
    if (!keep) req = 1'b0;
    tick();                       // k+2
    clr_cnt = clr;
    tick();                       // k+3
    clr_cnt = 1'b0;
    while (cyc < k + lat + 1) tick();
    last_ack = k + lat;
  endtask

  initial begin
    RSTb = 1'b0; req = 1'b0; op = 1'b0;
    single_err = 1'b0; double_err = 1'b0; clr_cnt = 1'b0;
    #1;
    check_zero("reset");
    tick(); tick();
    RSTb = 1'b1;
    tick();

    //     op se de clr keep b2b corr ue
    issue(0, 0, 0, 0, 0, 0, 0, 0);   // write
    issue(1, 0, 0, 0, 0, 0, 0, 0);   // clean read
    issue(1, 1, 0, 0, 0, 0, 1, 0);   // corrected read
    issue(0, 0, 0, 0, 0, 0, 1, 0);   // write clears err_corr
    issue(1, 0, 1, 0, 0, 0, 1, 1);   // uncorrectable
    issue(1, 1, 1, 0, 0, 0, 1, 2);   // both flags -> uncorrectable

    // reset in the middle of ENC: everything drops, no ack follows
    wait_idle();
    op = 1'b0; single_err = 1'b0; double_err = 1'b0; req = 1'b1;
    tick();                         // LOAD
    req = 1'b0;
    tick();                         // ENC
    chk("mid_enc_busy", int'(busy), 1);
    RSTb = 1'b0;
    #1;
    check_zero("midrst");
    tick(); tick();
    RSTb = 1'b1;
    repeat (10) tick();
    chk("post_rst_busy", int'(busy), 0);

    // saturation, back-to-back, clear racing an increment
    issue(1, 1, 0, 0, 1, 0, 1, 0);
    issue(1, 1, 0, 0, 1, 1, 2, 0);
    issue(1, 1, 0, 0, 1, 1, 3, 0);
    issue(1, 1, 0, 0, 1, 1, 3, 0);   // saturated
    issue(1, 1, 0, 1, 0, 1, 0, 0);   // clear wins over increment

    repeat (5) tick();
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
